// File: rtl/gearbox_tx_pkg.sv
// Shared PCS definitions for the 66b/64b transmit gearbox.
// Lane geometry, block type and sequence counter limits.
package gearbox_tx_pkg;

  localparam int LANE_N     = 4;
  localparam int HEAD_W     = 2;
  localparam int DATA_W     = 64;
  localparam int BLOCK_W    = HEAD_W + DATA_W;
  localparam int GB_SEQ_MAX = 32;
  localparam int GB_SEQ_W   = 6;

  typedef logic [BLOCK_W-1:0] gb_block_t;

endpackage

// File: rtl/gearbox_tx_lane.sv
// One lane of the 66b->64b gearbox: shift/merge datapath
// plus the residual register that carries leftover bits.
module gearbox_tx_lane #(
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        seq,
  input  logic              acc,
  input  logic              drn,
  input  logic [HEAD_W-1:0] head,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] word
);
  import gearbox_tx_pkg::*;

  localparam int BLK_W  = HEAD_W + DATA_W;
  localparam int WIDE_W = 2 * DATA_W;

  logic [BLK_W-1:0]  blk;
  logic [6:0]        sh;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] occ;
  logic [DATA_W-1:0] res_m;
  logic [WIDE_W-1:0] blk_sh;
  logic [WIDE_W-1:0] wide;

  // Place the new block above the valid residual bits.
  // Bits above occupancy are masked so they never leak out.
  always_comb begin
    blk    = {data, head};
    sh     = {seq, 1'b0};
    occ    = '1;
    if (seq < 6'(GB_SEQ_MAX))
      occ  = (DATA_W'(1) << sh) - DATA_W'(1);
    res_m  = res_q & occ;
    blk_sh = {{(WIDE_W-BLK_W){1'b0}}, blk} << sh;
    wide   = blk_sh | {{DATA_W{1'b0}}, res_m};
  end

  // Low half goes out; high half becomes the new residual.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      word  <= '0;
    end else if (acc) begin
      word  <= wide[DATA_W-1:0];
      res_q <= wide[WIDE_W-1:DATA_W];
    end else if (drn) begin
      word  <= res_m;
      res_q <= '0;
    end
  end

endmodule

// File: rtl/gearbox_tx.sv
// Per-lane 66b->64b transmit gearbox after AM insertion.
// Shared sequence counter; one idle input slot every 33 cycles.
module gearbox_tx #(
  parameter int LANE_N = 4,
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [LANE_N*DATA_W-1:0] data_o
);
  import gearbox_tx_pkg::*;

  logic [GB_SEQ_W-1:0] seq_q;
  logic [GB_SEQ_W-1:0] seq_d;
  logic                acc;
  logic                drn;

  assign ready_o = (seq_q != GB_SEQ_W'(GB_SEQ_MAX));
  assign acc     = valid_i & ready_o;
  assign drn     = ~ready_o;

  // Next sequence value: step on accept, wrap after drain.
  always_comb begin
    seq_d = seq_q;
    unique case (1'b1)
      drn:     seq_d = '0;
      acc:     seq_d = seq_q + GB_SEQ_W'(1);
      default: seq_d = seq_q;
    endcase
  end

  // Sequence counter and output-valid register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q   <= '0;
      valid_o <= 1'b0;
    end else begin
      seq_q   <= seq_d;
      valid_o <= acc | drn;
    end
  end

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    gearbox_tx_lane #(
      .HEAD_W (HEAD_W),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .seq   (seq_q),
      .acc   (acc),
      .drn   (drn),
      .head  (head_i[l*HEAD_W +: HEAD_W]),
      .data  (data_i[l*DATA_W +: DATA_W]),
      .word  (data_o[l*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_gearbox_tx.sv
// Bench for gearbox_tx: random traffic against a serial
// bit-stream reference model (one bit FIFO shared by lane).
module tb_gearbox_tx;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_i = 1'b0;
  logic [7:0]   head_i = '0;
  logic [255:0] data_i = '0;
  logic         ready_o;
  logic         valid_o;
  logic [255:0] data_o;

  gearbox_tx dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .head_i  (head_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference: serial stream, entry bit l belongs to lane l.
  logic [3:0]   bq[$];
  int           m_acc;
  logic [255:0] m_last;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic m_reset();
    bq.delete();
    m_acc  = 0;
    m_last = '0;
  endtask

  function automatic logic [255:0] rnd_d();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive after negedge, check after posedge.
  task automatic cyc(input bit v,
                     input logic [7:0] hd,
                     input logic [255:0] dt);
    bit           acc;
    bit           drn;
    logic [3:0]   e;
    logic [255:0] w;
    valid_i = v;
    head_i  = hd;
    data_i  = dt;
    #1;
    check("ready", 256'(ready_o), 256'(m_acc != 32));
    drn = (m_acc == 32);
    acc = v && !drn;
    @(posedge clk);
    #1;
    if (acc) begin
      for (int b = 0; b < 66; b++) begin
        for (int l = 0; l < 4; l++)
          e[l] = (b < 2) ? hd[l*2+b] : dt[l*64+b-2];
        bq.push_back(e);
      end
      m_acc++;
    end
    if (drn) m_acc = 0;
    check("valid", 256'(valid_o), 256'(acc || drn));
    if (acc || drn) begin
      w = '0;
      for (int i = 0; i < 64; i++) begin
        e = '0;
        if (bq.size() > 0) e = bq.pop_front();
        for (int l = 0; l < 4; l++) w[l*64+i] = e[l];
      end
      m_last = w;
    end
    check("data", data_o, m_last);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_valid", 256'(valid_o), '0);
    check("rst_data", data_o, '0);
    m_reset();
    @(negedge clk);
    reset   = 1'b0;
    valid_i = 1'b0;
    #1;
    check("rst_ready", 256'(ready_o), 256'(1));
  endtask

  logic [255:0] dt;
  logic [7:0]   hd;

  initial begin
    m_reset();
    @(negedge clk);
    do_reset();

    // First block: lane0 head 01, data 0.
    dt = rnd_d();
    dt[63:0] = '0;
    hd = 8'($urandom);
    hd[1:0] = 2'b01;
    cyc(1'b1, hd, dt);
    check("first_word", 256'(data_o[63:0]), 256'(64'h1));

    // Two full periods, counter data, alternating head.
    do_reset();
    for (int c = 0; c < 66; c++) begin
      dt = rnd_d();
      dt[63:0] = 64'(c);
      hd = 8'($urandom);
      hd[1:0] = (c % 2 == 1) ? 2'b10 : 2'b01;
      cyc(1'b1, hd, dt);
    end

    // Stall three cycles at seq 10.
    do_reset();
    for (int c = 0; c < 10; c++) cyc(1'b1, 8'($urandom), rnd_d());
    for (int c = 0; c < 3; c++) cyc(1'b0, 8'($urandom), rnd_d());
    for (int c = 0; c < 25; c++) cyc(1'b1, 8'($urandom), rnd_d());

    // Drain with valid low.
    do_reset();
    for (int c = 0; c < 32; c++) cyc(1'b1, 8'($urandom), rnd_d());
    cyc(1'b0, 8'($urandom), rnd_d());
    for (int c = 0; c < 3; c++) cyc(1'b1, 8'($urandom), rnd_d());

    // Reset at seq 20 with live residual.
    do_reset();
    for (int c = 0; c < 20; c++) cyc(1'b1, 8'($urandom), rnd_d());
    do_reset();
    dt = rnd_d();
    hd = 8'($urandom);
    cyc(1'b1, hd, dt);
    check("post_rst", 256'(data_o[63:0]), 256'({dt[61:0], hd[1:0]}));

    // Lane independence.
    do_reset();
    for (int l = 0; l < 4; l++)
      dt[l*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(l);
    for (int c = 0; c < 34; c++) cyc(1'b1, 8'hAA, dt);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 400; c++)
      cyc($urandom_range(0, 9) < 8, 8'($urandom), rnd_d());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gearbox_tx.md
Name: gearbox_tx

Overview:
- Per-lane 66b to 64b transmit gearbox placed directly downstream of the alignment-marker insertion stage, am_tx.
- Takes one 66-bit block per lane per accepted cycle. Each block is a 2-bit sync header plus 64-bit payload.
- Emits a continuous 64-bit word per lane toward the PMA/serdes.
- Absorbs the 2-bit-per-block overhead by refusing input for one cycle in every 33, and back-pressures the upstream pipeline through ready_o.

Parameters:
- LANE_N, 4, number of PCS lanes processed in parallel.
- HEAD_W, 2, sync header width per lane.
- DATA_W, 64, block payload width per lane. This is also the output word width.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  head_i/data_i hold a block for every lane.
- head_i  input  LANE_N*HEAD_W  sync headers; lane l at [l*2+:2].
- data_i  input  LANE_N*DATA_W  payloads; lane l at [l*64+:64].
- ready_o  output  1  gearbox accepts a block this cycle. Transfer happens when valid_i && ready_o.
- valid_o  output  1  data_o holds a new word.
- data_o  output  LANE_N*DATA_W  gearboxed words; lane l at [l*64+:64]. Bit 0 is transmitted first.

Behaviour:
- Serial order per block is {data, head}: head[0] first, then head[1], then data[0] through data[63].
- Shared sequence counter seq, 6 bits, counts 0..32. It is shared by all lanes.
- Each lane holds a residual buffer res, up to 64 bits. Occupancy is 2*seq bits.
- Reset (async, active-high) clears:
  - seq=0
  - all residual buffers
  - valid_o=0
  - data_o=0
- ready_o is combinational: ready_o = (seq != 32). It does not depend on valid_i.
- Accept cycle (seq<32 and valid_i):
  - Form per lane blk={data,head}, 66 bits, and W = (blk << 2*seq) | res.
  - Next-cycle outputs: data_o = W[63:0], valid_o=1.
  - Residual update: res = W[2*seq+65:64], which is 2*seq+2 bits.
  - seq increments.
- Drain cycle (seq==32):
  - No input consumed, regardless of valid_i.
  - Next-cycle outputs: data_o = res[63:0], valid_o=1.
  - res cleared, seq returns to 0.
- Stall cycle (seq<32 and !valid_i):
  - valid_o=0 next cycle; data_o holds its previous value.
  - seq and res are unchanged.
- Latency: registered output. data_o appears one cycle after the accept or drain cycle.
- Steady state with valid_i always high:
  - 32 accepts followed by 1 drain, a 33-cycle period.
  - valid_o is high every cycle from the second cycle after reset release.
- Reset mid-operation: residual bits are discarded with no flush. The first accept after release starts at bit offset 0.
- Unused residual bits above the occupancy are don't-care internally. They must never reach data_o.
- All lanes share seq and the handshake. There is no per-lane skew.

Decomposition:
- Shared PCS package holds:
  - LANE_N, HEAD_W, DATA_W
  - BLOCK_W=66
  - GB_SEQ_MAX=32
  - GB_SEQ_W=6
  - a typedef for the 66-bit block
- Top module holds the seq counter, ready_o and valid_o.
- One sub-module, gearbox_tx_lane, is instantiated LANE_N times. It takes seq, an accept strobe and a drain strobe, and holds the shift/merge datapath and residual register for one lane.

Test Plan:
- Reset check: assert reset mid-cycle -> immediately valid_o=0, data_o=0. After release -> ready_o=1, seq=0.
- First block, lane0 head=2'b01, data=64'h0 accepted at seq 0 -> next cycle lane0 data_o=64'h1, valid_o=1. Residual is 2 bits = 2'b00.
- Full period: 33 cycles of valid_i=1 with lane0 data=incrementing counter, head alternating 01/10.
  - ready_o low only on cycle 33.
  - Concatenated data_o over 33 words equals the serial concatenation of the 32 {data,head} blocks, with no missing or duplicated bits.
  - The pattern repeats on the next period.
- Stall: drop valid_i for 3 cycles at seq 10.
  - valid_o low for exactly 3 cycles; data_o is held.
  - seq stays 10.
  - Reconstructed stream is identical to the no-stall run, and ready_o still drops after 32 accepts.
- Drain with valid_i=0 at seq 32: drain still occurs, valid_o=1 with the 64 residual bits, and seq returns to 0.
- Reset at seq 20 with non-zero residual: after release, the first word equals {data,head}[63:0] of the next accepted block. No old residual bits leak into it.
- Lane independence: each lane l is driven with data=64'hA5A5_0000_0000_0000|l and head=2'b10 for 33 cycles. Each lane reconstructs only its own pattern.
